// File: rtl/onehot_stream_checker.sv
// Registered one-hot / one-cold stream monitor.
// Classifies each accepted beat and tracks violation count and alarm.
module onehot_stream_checker #(
  parameter  int WIDTH        = 8,
  parameter  int CNT_W        = 8,
  parameter  int ALARM_THRESH = 3,
  parameter  int ALLOW_ZERO   = 0,
  localparam int IDX_W        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_one_hot,
  output logic [IDX_W-1:0] index,
  output logic             zero_flag,
  output logic             multi_flag,
  output logic [CNT_W-1:0] err_count,
  output logic             alarm
);

  localparam logic [7:0] THR = 8'(ALARM_THRESH);

  logic [WIDTH-1:0] act;
  logic             zero_c;
  logic             multi_c;
  logic             ohot_c;
  logic [IDX_W-1:0] idx_c;
  logic             accept;
  logic [7:0]       run_q;
  logic [7:0]       run_inc;

  // Ready whenever the single result slot is free or draining.
  assign in_ready = rst_n && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Classify the incoming word and priority-encode its lowest active bit.
  always_comb begin
    act     = mode ? ~data_in : data_in;
    zero_c  = (act == '0);
    multi_c = ((act & (act - WIDTH'(1))) != '0);
    ohot_c  = !multi_c && (!zero_c || (ALLOW_ZERO != 0));
    idx_c   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (act[i]) idx_c = IDX_W'(i);
    end
  end

  // Run counter increments toward the threshold and saturates there.
  always_comb begin
    run_inc = (run_q >= THR) ? run_q : run_q + 8'd1;
  end

  // Output register: load on accept, drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      is_one_hot <= 1'b0;
      index      <= '0;
      zero_flag  <= 1'b0;
      multi_flag <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      is_one_hot <= ohot_c;
      index      <= idx_c;
      zero_flag  <= zero_c;
      multi_flag <= multi_c;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Violation bookkeeping; clr takes priority over a same-cycle beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      run_q     <= '0;
      alarm     <= 1'b0;
    end else if (clr) begin
      err_count <= '0;
      run_q     <= '0;
      alarm     <= 1'b0;
    end else if (accept) begin
      if (!ohot_c) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
        run_q <= run_inc;
        if (run_inc >= THR) alarm <= 1'b1;
      end else begin
        run_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_stream_checker.sv
// Bench for onehot_stream_checker: vector table, corner
// sequences and random traffic against a reference model.
module tb_onehot_stream_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv, md, clr, ordy;
  logic [7:0] din;
  logic       ir, ov, oh, zf, mf, al;
  logic [2:0] idx;
  logic [7:0] ec;

  logic       iv2;
  logic [7:0] din2;
  logic       ir2, ov2, oh2, zf2, mf2, al2;
  logic [2:0] idx2;
  logic [1:0] ec2;

  int checks = 0;
  int errors = 0;

  bit         m_ov, m_oh, m_z, m_m, m_al;
  logic [2:0] m_idx;
  int         m_err, m_run;

  always #5 clk = ~clk;

  onehot_stream_checker #(
    .WIDTH(8), .CNT_W(8), .ALARM_THRESH(3), .ALLOW_ZERO(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
    .data_in(din), .mode(md), .clr(clr), .out_valid(ov),
    .out_ready(ordy), .is_one_hot(oh), .index(idx),
    .zero_flag(zf), .multi_flag(mf), .err_count(ec), .alarm(al)
  );

  onehot_stream_checker #(
    .WIDTH(8), .CNT_W(2), .ALARM_THRESH(3), .ALLOW_ZERO(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .data_in(din2), .mode(1'b0), .clr(1'b0), .out_valid(ov2),
    .out_ready(1'b1), .is_one_hot(oh2), .index(idx2),
    .zero_flag(zf2), .multi_flag(mf2), .err_count(ec2), .alarm(al2)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       m;
    logic       c;
    logic       r;
    logic       e_ov;
    logic       e_oh;
    logic [2:0] e_idx;
    logic       e_z;
    logic       e_mu;
    int         e_err;
    logic       e_al;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference classification from counting active bits.
  task automatic classify(input logic [7:0] d, input logic m, input bit az,
                          output bit z, output bit mu, output bit o,
                          output logic [2:0] ix);
    logic [7:0] a;
    int n;
    a  = m ? ~d : d;
    n  = $countones(a);
    z  = (n == 0);
    mu = (n > 1);
    o  = !mu && (!z || az);
    ix = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) begin
        ix = 3'(i);
        break;
      end
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_oh = 0; m_z = 0; m_m = 0; m_al = 0;
    m_idx = '0; m_err = 0; m_run = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, ov, m_ov);
    chk({tag, ".is_one_hot"}, oh, m_oh);
    chk({tag, ".index"}, idx, m_idx);
    chk({tag, ".zero_flag"}, zf, m_z);
    chk({tag, ".multi_flag"}, mf, m_m);
    chk({tag, ".err_count"}, ec, m_err);
    chk({tag, ".alarm"}, al, m_al);
  endtask

  // One clock of main-DUT traffic; entered and left at posedge+1.
  task automatic cyc(input logic v, input logic [7:0] d, input logic m,
                     input logic c, input logic r, input string tag);
    bit acc, z, mu, o;
    logic [2:0] ix;
    iv = v; din = d; md = m; clr = c; ordy = r;
    #1;
    chk({tag, ".in_ready"}, ir, !m_ov || r);
    acc = v && (!m_ov || r);
    classify(d, m, 1'b0, z, mu, o, ix);
    @(posedge clk);
    if (acc) begin
      m_ov = 1; m_oh = o; m_z = z; m_m = mu; m_idx = ix;
    end else if (r) begin
      m_ov = 0;
    end
    if (c) begin
      m_err = 0; m_run = 0; m_al = 0;
    end else if (acc) begin
      if (!o) begin
        if (m_err < 255) m_err++;
        if (m_run < 3) m_run++;
        if (m_run >= 3) m_al = 1;
      end else begin
        m_run = 0;
      end
    end
    #1;
    check_outs(tag);
  endtask

  task automatic cyc2(input logic [7:0] d);
    iv2 = 1'b1; din2 = d;
    @(posedge clk);
    #1;
    iv2 = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1, 8'h10, 0, 0, 1, 1, 1, 3'd4, 0, 0, 0, 0};
    vt[1]  = '{1, 8'h28, 0, 0, 1, 1, 0, 3'd3, 0, 1, 1, 0};
    vt[2]  = '{1, 8'h00, 0, 0, 1, 1, 0, 3'd0, 1, 0, 2, 0};
    vt[3]  = '{1, 8'hFD, 1, 0, 1, 1, 1, 3'd1, 0, 0, 2, 0};
    vt[4]  = '{1, 8'hFF, 1, 0, 1, 1, 0, 3'd0, 1, 0, 3, 0};
    vt[5]  = '{1, 8'h03, 0, 0, 1, 1, 0, 3'd0, 0, 1, 4, 0};
    vt[6]  = '{1, 8'hC0, 0, 0, 1, 1, 0, 3'd6, 0, 1, 5, 1};
    vt[7]  = '{1, 8'h80, 0, 0, 1, 1, 1, 3'd7, 0, 0, 5, 1};
    vt[8]  = '{0, 8'h00, 0, 1, 1, 0, 1, 3'd7, 0, 0, 0, 0};
    vt[9]  = '{1, 8'h0F, 0, 1, 1, 1, 0, 3'd0, 0, 1, 0, 0};
    vt[10] = '{1, 8'h7F, 1, 0, 1, 1, 1, 3'd7, 0, 0, 0, 0};

    iv = 0; din = '0; md = 0; clr = 0; ordy = 1;
    iv2 = 0; din2 = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("rst.out_valid", ov, 0);
    chk("rst.in_ready", ir, 0);
    chk("rst.err_count", ec, 0);
    chk("rst.alarm", al, 0);
    chk("rst.index", idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel.in_ready", ir, 1);

    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].v, vt[i].d, vt[i].m, vt[i].c, vt[i].r, "vec");
      chk("vec.ov", ov, vt[i].e_ov);
      chk("vec.oh", oh, vt[i].e_oh);
      chk("vec.idx", idx, vt[i].e_idx);
      chk("vec.zero", zf, vt[i].e_z);
      chk("vec.multi", mf, vt[i].e_mu);
      chk("vec.err", ec, vt[i].e_err);
      chk("vec.alarm", al, vt[i].e_al);
    end

    // Stall: result held, counters frozen, then drain.
    cyc(1, 8'h28, 0, 0, 1, "st0");
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'h06, 0, 0, 0, "stall");
      chk("stall.in_ready", ir, 0);
      chk("stall.idx", idx, 3);
      chk("stall.err", ec, 1);
    end
    cyc(1, 8'h06, 0, 0, 1, "drain");
    chk("drain.idx", idx, 1);
    chk("drain.err", ec, 2);
    cyc(0, 8'h00, 0, 0, 1, "idle");
    chk("idle.ov", ov, 0);
    chk("idle.err", ec, 2);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic v, m, c, r;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      m = $urandom_range(0, 1);
      c = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) d = 8'h01 << $urandom_range(0, 7);
      else d = 8'($urandom);
      if (m && $urandom_range(0, 1) == 1) d = ~d;
      cyc(v, d, m, c, r, "rnd");
    end

    // Asynchronous reset during a stall.
    cyc(1, 8'h03, 0, 0, 1, "pre");
    cyc(1, 8'h05, 0, 0, 0, "pre_stall");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.out_valid", ov, 0);
    chk("arst.in_ready", ir, 0);
    chk("arst.is_one_hot", oh, 0);
    chk("arst.index", idx, 0);
    chk("arst.multi", mf, 0);
    chk("arst.zero", zf, 0);
    chk("arst.err_count", ec, 0);
    chk("arst.alarm", al, 0);
    iv = 0; ordy = 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 8'h20, 0, 0, 1, "post");
    chk("post.idx", idx, 5);

    // Narrow counter saturation and allowed-zero on dut2.
    for (int k = 1; k <= 5; k++) begin
      cyc2(8'h03);
      chk("sat.err", ec2, (k > 3) ? 3 : k);
      chk("sat.alarm", al2, (k >= 3) ? 1 : 0);
    end
    cyc2(8'h00);
    chk("az.one_hot", oh2, 1);
    chk("az.zero", zf2, 1);
    chk("az.err", ec2, 3);
    chk("az.ov", ov2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end, expected finish");
    $fatal(1);
  end

endmodule
